// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    // Receive FSM states; anything other than IDLE means a frame is in flight
    // or the line is being waited on.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit line; resets to idle-high.
// Latency: 2 clock cycles from async_i to sync_o.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high reset (both flops go to 1)
//   async_i - asynchronous input line
//   sync_o  - synchronised copy of async_i
module uart_bit_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receive front end with mid-bit sampling and a one-entry byte buffer.
// Latency: rx_full rises ~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge.
// Backpressure: buffer freed by rx_ack; a good byte arriving while full is dropped (rx_overrun).
//
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   rx_bit        - asynchronous serial line, idle high
//   rx_ack        - consumer has read rx_data; frees the buffer
//   rx_data       - last accepted byte (LSB received first)
//   rx_full       - buffer holds an unread byte
//   rx_valid      - one-cycle pulse when a byte is loaded
//   rx_frame_err  - one-cycle pulse when the stop bit is sampled low
//   rx_overrun    - sticky: a good byte was dropped because the buffer was full
//   rx_busy       - FSM not in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_bit,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_full,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic                      rx_s;
    rx_state_e                 state_q;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [7:0]                data_q;
    logic                      full_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      overrun_q;

    uart_bit_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (rx_bit),
        .sync_o  (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            // Consumer read. A frame completing on this same edge overrides
            // these assignments further down.
            if (rx_ack && full_q) begin
                full_q    <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end

                // Re-check the line half a bit in; a high here was a glitch.
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            if (!full_q || rx_ack) begin
                                // Empty, or being read on this very edge:
                                // the new byte takes the slot and overrun
                                // keeps whatever it held before.
                                data_q    <= shift_q;
                                full_q    <= 1'b1;
                                valid_q   <= 1'b1;
                                overrun_q <= overrun_q;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                // Break or stuck-low line: no new start bit until it idles.
                WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data      = data_q;
    assign rx_full      = full_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = overrun_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CLKS = 16;

    logic       clock;
    logic       reset;
    logic       rx_bit;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_full;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_bit       (rx_bit),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_full      (rx_full),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Cycle counter and output monitors.
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    bit busy_seen = 1'b0;
    int start_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (rx_frame_err) ferr_cnt++;
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    // Reference model of the receive buffer, at transaction level.
    logic [7:0] m_data;
    bit         m_full;
    bit         m_overrun;
    int         m_vcnt = 0;
    int         m_fcnt = 0;

    task automatic model_reset();
        m_data = 8'h00; m_full = 0; m_overrun = 0;
    endtask

    // A correctly framed byte arrives with no read on the same edge.
    task automatic model_good(input logic [7:0] b);
        if (!m_full) begin
            m_data = b; m_full = 1; m_vcnt++;
        end else begin
            m_overrun = 1;
        end
    endtask

    // Serial driver: called and returns at posedge + 1.
    task automatic send_bit(input logic b);
        rx_bit = b;
        repeat (CLKS) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_bit = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(posedge clock); #1;
        rx_ack = 1'b0;
        if (m_full) begin
            m_full = 0; m_overrun = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_bit = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if ({rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy});
        end
        idle(5);
    endtask

    task automatic test_single_byte();
        int lat;
        send_frame(8'hA5, 1'b1);
        model_good(8'hA5);
        lat = last_valid_cyc - start_cyc;
        checks++; if (valid_cnt !== m_vcnt) begin errors++; $display("FAIL single_valid_cnt got=%0d exp=%0d", valid_cnt, m_vcnt); end
        // 2 + CLKS/2 + 9*CLKS = 154, tolerance one cycle
        checks++; if (lat < 153 || lat > 155) begin errors++; $display("FAIL single_latency got=%0d exp=154+-1", lat); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", rx_data); end
        checks++; if (rx_full !== 1'b1 || rx_overrun !== 1'b0 || ferr_cnt !== m_fcnt) begin
            errors++; $display("FAIL single_flags full=%b ovr=%b ferr=%0d exp 1 0 %0d", rx_full, rx_overrun, ferr_cnt, m_fcnt);
        end
        do_ack();
        checks++; if (rx_full !== 1'b0 || rx_data !== 8'hA5) begin
            errors++; $display("FAIL single_ack full=%b data=%h exp 0 a5", rx_full, rx_data);
        end
        idle(4);
    endtask

    task automatic test_random_bytes();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            bit ack_it;
            b = 8'($urandom);
            ack_it = 1'($urandom_range(0, 1));
            send_frame(b, 1'b1);
            model_good(b);
            checks++; if (rx_data !== m_data || rx_full !== m_full || rx_overrun !== m_overrun) begin
                errors++; $display("FAIL random_%0d data=%h full=%b ovr=%b exp %h %b %b", i, rx_data, rx_full, rx_overrun, m_data, m_full, m_overrun);
            end
            if (ack_it) do_ack();
            idle($urandom_range(1, 6));
        end
        checks++; if (valid_cnt !== m_vcnt) begin errors++; $display("FAIL random_valid_cnt got=%0d exp=%0d", valid_cnt, m_vcnt); end
        do_ack();
        idle(2);
    endtask

    task automatic test_glitch();
        busy_seen = 1'b0;
        rx_bit = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        idle(30);
        checks++; if (busy_seen !== 1'b1 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy seen=%b now=%b exp 1 0", busy_seen, rx_busy);
        end
        checks++; if (valid_cnt !== m_vcnt || rx_data !== m_data) begin
            errors++; $display("FAIL glitch_output vcnt=%0d data=%h exp %0d %h", valid_cnt, rx_data, m_vcnt, m_data);
        end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0);
        m_fcnt++;
        rx_bit = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        checks++; if (ferr_cnt !== m_fcnt) begin errors++; $display("FAIL ferr_count got=%0d exp=%0d", ferr_cnt, m_fcnt); end
        checks++; if (rx_full !== 1'b0 || valid_cnt !== m_vcnt || rx_busy !== 1'b1) begin
            errors++; $display("FAIL ferr_state full=%b vcnt=%0d busy=%b exp 0 %0d 1", rx_full, valid_cnt, rx_busy, m_vcnt);
        end
        idle(10);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_release busy=%b exp=0", rx_busy); end
        send_frame(8'h3C, 1'b1);
        model_good(8'h3C);
        checks++; if (rx_data !== 8'h3C || rx_full !== 1'b1 || ferr_cnt !== m_fcnt) begin
            errors++; $display("FAIL ferr_recover data=%h full=%b ferr=%0d exp 3c 1 %0d", rx_data, rx_full, ferr_cnt, m_fcnt);
        end
        do_ack();
        idle(3);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1); model_good(8'h11);
        idle(3);
        send_frame(8'h22, 1'b1); model_good(8'h22);
        checks++; if (rx_data !== 8'h11 || rx_overrun !== 1'b1 || rx_full !== 1'b1) begin
            errors++; $display("FAIL overrun_set data=%h ovr=%b full=%b exp 11 1 1", rx_data, rx_overrun, rx_full);
        end
        do_ack();
        checks++; if (rx_full !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clear full=%b ovr=%b exp 0 0", rx_full, rx_overrun);
        end
        idle(3);
    endtask

    // Send b with rx_ack high on exactly the stop-bit sampling edge
    // (155th rising edge after the start bit is driven).
    task automatic send_with_sim_ack(input logic [7:0] b);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (154) @(posedge clock);
                #1 rx_ack = 1'b1;
                @(posedge clock);
                #1 rx_ack = 1'b0;
            end
        join
        m_data = b; m_full = 1; m_vcnt++;
    endtask

    task automatic test_simultaneous_ack();
        int v0;
        send_frame(8'h11, 1'b1); model_good(8'h11);
        idle(3);
        v0 = valid_cnt;
        send_with_sim_ack(8'h22);
        checks++; if (rx_data !== 8'h22 || rx_full !== 1'b1 || rx_overrun !== 1'b0) begin
            errors++; $display("FAIL simack_state data=%h full=%b ovr=%b exp 22 1 0", rx_data, rx_full, rx_overrun);
        end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL simack_valid pulses=%0d exp=1", valid_cnt - v0); end
        // With overrun already set, a simultaneous read+load must keep it.
        idle(3);
        send_frame(8'h33, 1'b1); model_good(8'h33);
        idle(3);
        send_with_sim_ack(8'h44);
        checks++; if (rx_data !== m_data || rx_full !== m_full || rx_overrun !== m_overrun) begin
            errors++; $display("FAIL simack_sticky data=%h full=%b ovr=%b exp %h %b %b", rx_data, rx_full, rx_overrun, m_data, m_full, m_overrun);
        end
        do_ack();
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h77, 1'b1); model_good(8'h77);
        idle(3);
        rx_bit = 1'b0;
        repeat (CLKS) @(posedge clock);
        #1 rx_bit = 1'b1;
        repeat (3 * CLKS) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        checks++; if (rx_data !== 8'h00 || {rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy} !== 5'b0) begin
            errors++; $display("FAIL midreset_outputs data=%h flags=%b exp 00 00000", rx_data, {rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy});
        end
        idle(120);
        checks++; if (rx_busy !== 1'b0 || rx_full !== 1'b0) begin
            errors++; $display("FAIL midreset_idle busy=%b full=%b exp 0 0", rx_busy, rx_full);
        end
        send_frame(8'h5A, 1'b1); model_good(8'h5A);
        checks++; if (rx_data !== 8'h5A || rx_full !== 1'b1 || ferr_cnt !== m_fcnt || valid_cnt !== m_vcnt) begin
            errors++; $display("FAIL midreset_next data=%h full=%b ferr=%0d vcnt=%0d exp 5a 1 %0d %0d", rx_data, rx_full, ferr_cnt, valid_cnt, m_fcnt, m_vcnt);
        end
    endtask

    initial begin
        reset = 1'b1; rx_bit = 1'b1; rx_ack = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_single_byte();
        test_random_bytes();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_simultaneous_ack();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
